// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux packet demultiplexer.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/stream_demux_oreg.sv
// One-deep output register tagged with its destination channel; drives the
// one-hot valid and drains on the ready of the tagged channel only.
module stream_demux_oreg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SEL_W-1:0]  ld_ch,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [N_OUT-1:0]  m_ready,
  output logic              can_load,
  output logic [SEL_W-1:0]  ch,
  output logic [N_OUT-1:0]  m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam logic [N_OUT-1:0] ONE = {{(N_OUT-1){1'b0}}, 1'b1};

  logic              vld_p1;
  logic [SEL_W-1:0]  ch_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;
  logic [N_OUT-1:0]  onehot_p1;
  logic              drain;

  assign drain    = vld_p1 && m_ready[ch_p1];
  assign can_load = !vld_p1 || m_ready[ch_p1];

  // p0 -> p1: load wins over drain so a new beat can replace a draining one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      ch_p1     <= '0;
      data_p1   <= '0;
      last_p1   <= 1'b0;
      onehot_p1 <= '0;
    end else if (load) begin
      vld_p1    <= 1'b1;
      ch_p1     <= ld_ch;
      data_p1   <= ld_data;
      last_p1   <= ld_last;
      onehot_p1 <= ONE << ld_ch;
    end else if (drain) begin
      vld_p1    <= 1'b0;
      onehot_p1 <= '0;
    end
  end

  assign ch      = ch_p1;
  assign m_valid = onehot_p1;
  assign m_data  = data_p1;
  assign m_last  = last_p1;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N packet demux: channel locked per packet on its first beat,
// disabled or out-of-range packets are discarded and counted.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  input  logic [SEL_W-1:0]      s_sel,
  output logic [N_OUT-1:0]      m_valid,
  input  logic [N_OUT-1:0]      m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  state_t                  state_p0, state_nxt;
  logic [DROP_CNT_W-1:0]   drop_cnt_p0;
  logic                    load, drop_inc, can_load, accept, in_range;
  logic [SEL_W-1:0]        ch_cur, ld_ch;

  generate
    if (N_OUT == (1 << SEL_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = {1'b0, s_sel} < (SEL_W+1)'(N_OUT);
    end
  endgenerate

  assign s_ready = (state_p0 == DROP) || can_load;
  assign accept  = s_valid && s_ready;
  assign ld_ch   = (state_p0 == IDLE) ? s_sel : ch_cur;

  always_comb begin
    state_nxt = state_p0;
    load      = 1'b0;
    drop_inc  = 1'b0;
    case (state_p0)
      IDLE: if (accept) begin
        if (en && in_range) begin
          load = 1'b1;
          if (!s_last) state_nxt = PASS;
        end else begin
          drop_inc = 1'b1;
          if (!s_last) state_nxt = DROP;
        end
      end
      PASS: if (accept) begin
        load = 1'b1;
        if (s_last) state_nxt = IDLE;
      end
      DROP: if (accept && s_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: packet state and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0    <= IDLE;
      drop_cnt_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (drop_inc) drop_cnt_p0 <= sat_inc(drop_cnt_p0);
    end
  end

  assign drop_cnt = drop_cnt_p0;

  stream_demux_oreg #(
    .DATA_W(DATA_W),
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .ld_ch   (ld_ch),
    .ld_data (s_data),
    .ld_last (s_last),
    .m_ready (m_ready),
    .can_load(can_load),
    .ch      (ch_cur),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last)
  );

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N packet demultiplexer with valid/ready handshakes. It is the parametrised successor of the team's 8-way combinational demux.
- Routes a single input stream to one of N_OUT output channels. The channel is chosen per packet: it is sampled on the first beat and locked until the beat carrying s_last.
- Packets are discarded when the block is disabled or the select is out of range.
- Sits between a single upstream producer and N consumers on the datapath fabric.

Parameters:
- DATA_W, 8, width of the data payload.
- N_OUT, 8, number of output channels. Legal range 2..256.
- SEL_W, $clog2(N_OUT), width of the select. Treated as derived; overriding it is illegal.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  enable, sampled only on a packet's first beat.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  input payload.
- s_last  in  1  last beat of packet.
- s_sel  in  SEL_W  destination channel, sampled on first beat.
- m_valid  out  N_OUT  one-hot (or zero) output valid.
- m_ready  in  N_OUT  per-channel ready.
- m_data  out  DATA_W  payload, shared by all channels.
- m_last  out  1  last flag, shared by all channels.
- drop_cnt  out  16  count of dropped packets, saturating.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - Output register goes empty: m_valid=0, m_data=0, m_last=0.
  - drop_cnt=0, lock channel=0.
  - Any in-flight beat is lost.
- Output register: one beat deep, tagged with channel ch_q.
  - m_valid = full_q ? (1<<ch_q) : 0.
  - The register drains when m_ready[ch_q] is high.
- Latency: an accepted beat appears on m_* on the next cycle. Throughput is one beat per cycle when the consumer holds ready high.
- s_ready:
  - In DROP: always 1.
  - Otherwise: !full_q || m_ready[ch_q].
  - s_ready is combinational from m_ready. There is no combinational path from s_valid to s_ready.
- FSM states:
  - IDLE: waiting for a first beat. On an accepted beat:
    - If en=1 and s_sel<N_OUT: load the beat, set ch_q=s_sel, go to PASS (or stay in IDLE if s_last=1).
    - Otherwise: discard the beat, increment drop_cnt, go to DROP (or stay in IDLE if s_last=1). The increment happens once per packet, on its first beat.
  - PASS: accepted beats are loaded with ch_q unchanged. s_sel and en are ignored. An accepted s_last returns the FSM to IDLE.
  - DROP: accepted beats are discarded. An accepted s_last returns the FSM to IDLE.
- Single-beat packet (s_last on the first beat): handled entirely in IDLE; there is no PASS/DROP visit.
- Back-to-back packets to different channels:
  - A new first beat may load in the same cycle the previous beat drains (full_q && m_ready[ch_q]). ch_q switches in that cycle.
  - m_valid never shows two bits set and never drops a beat.
- en deasserted mid-packet: the current packet completes normally.
- sel out of range: possible only when N_OUT is not a power of 2. The packet is dropped.
- m_ready on channels other than ch_q: ignored.
- Stability: m_data, m_last and m_valid are held stable while m_valid is nonzero and m_ready[ch_q]=0.
- drop_cnt: saturates at 16'hFFFF and does not wrap.
- All outputs come from flops except s_ready.

Decomposition:
- Shared package:
  - FSM state typedef (IDLE, PASS, DROP), 2-bit encoding.
  - DROP_CNT_W=16.
- One natural sub-module: stream_demux_oreg. It is the one-deep tagged output register holding the full/ch/data/last flops and the drain logic. The FSM and counter stay in the top.

Test Plan:
- Basic routing:
  - Stimulus: en=1, single-beat packets with s_sel=0..7, data 8'hA0+sel, all m_ready=1.
  - Response: m_valid=1<<sel one cycle after each accept, m_data=8'hA0+sel, m_last=1, s_ready stays high, drop_cnt=0.
- Packet lock:
  - Stimulus: 4-beat packet with s_sel=3 on beat 0, s_sel changed to 5 and en=0 on beats 1-3.
  - Response: all 4 beats appear on m_valid=8'b0000_1000, with m_last only on beat 4.
- Backpressure:
  - Stimulus: m_ready[2]=0 for 5 cycles during a 3-beat packet to channel 2.
  - Response: s_ready=0 after the first beat is registered. m_data is held stable. Once ready is restored, the beats arrive in order with no loss or duplication.
- Drop:
  - Stimulus: en=0 on a 3-beat packet, then N_OUT=6 with s_sel=7.
  - Response: s_ready=1 throughout, m_valid=0, drop_cnt goes 0→1→2 on the first beats only.
- Switch and reset:
  - Stimulus: a last beat to ch1 followed immediately by a first beat to ch6, with m_ready all 1.
  - Response: m_valid goes 0x02 then 0x40 on consecutive cycles.
  - Then assert rst mid-packet: m_valid=0 immediately (asynchronously), FSM returns to IDLE, drop_cnt=0.
- Saturation:
  - Stimulus: force 65537 dropped packets (forcing the counter near the maximum is acceptable).
  - Response: drop_cnt holds at 16'hFFFF.
